pacman_soc_onchip_mem_arbiter: RTL and testbench
================================================

Name: pacman_soc_onchip_mem_arbiter

Overview:
- Two-master arbiter sharing the 4-word x 32-bit single-port on-chip RAM slave (2-bit word address, 4-bit byteenable, 1-cycle read latency).
- Sits in pacman_soc between the Nios data master (port 0) and the game-state engine (port 1), and the RAM's chipselect/write/address/byteenable/writedata/readdata pins.
- Round-robin arbitration with a bounded hold streak.
- Pipelined: one access accepted per cycle; read data returned with readdatavalid.

Parameters:
- HOLD_MAX, 1: maximum consecutive accepts the current owner may take while the other port is requesting; 1 gives pure round-robin. Legal range 1..15.
- ADDR_W, 2: word-address width; must match the RAM.
- DATA_W, 32: data width; the byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- reset_req  in  1  when high, no new accepts (RAM clock-enable hold)
- m0_address  in  ADDR_W  port 0 word address
- m0_byteenable  in  DATA_W/8  port 0 byte lanes
- m0_read  in  1  port 0 read request
- m0_write  in  1  port 0 write request
- m0_writedata  in  DATA_W  port 0 write data
- m0_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata  out  DATA_W  read data to port 0
- m0_readdatavalid  out  1  port 0 read data valid
- m1_*  same set as m0_*, for port 1
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte lanes
- mem_writedata  out  DATA_W  RAM write data
- mem_readdata  in  DATA_W  RAM output, valid 1 cycle after a read is issued

Behaviour:
- req_i = mi_read | mi_write. If both are high, the access is a write; the read is dropped and no readdatavalid is generated.
- Registered state:
  - last (port of the most recent accept)
  - streak (4-bit count of consecutive accepts by last)
  - rd_pend {valid, port}
- Reset (async): last=1 so port 0 wins the first contention; streak=0; rd_pend=0.
- Output reset values: both readdatavalid=0, both waitrequest=1 (no accepts while reset is high), mem_chipselect=0, mem_write=0, mem_address/byteenable/writedata=0.
- Grant selection (combinational, same cycle):
  - No request, or reset_req=1: no grant.
  - Only one port requesting: that port.
  - Both requesting: last keeps the grant if streak < HOLD_MAX; otherwise the other port.
- Accept: acc_i = grant==i. mi_waitrequest = ~acc_i, combinational. Masters hold their signals stable while waitrequest is high (Avalon rule).
- On accept, the mem_* outputs are driven from the granted port in the same cycle: chipselect=1, write=mi_write.
- With no accept, mem_chipselect=0, mem_write=0, and all other mem_* outputs are 0.
- Streak update on accept:
  - Port == last: streak = min(streak+1, 15).
  - Otherwise: last = port, streak = 1.
  - No accept: unchanged.
- Read return:
  - A read accept in cycle N sets rd_pend={1,port}.
  - In cycle N+1, m{port}_readdatavalid=1 and m{port}_readdata=mem_readdata.
  - Both readdata buses carry mem_readdata at all times; only readdatavalid is port-qualified.
  - rd_pend is reloaded every cycle (0 if no read accepted), so back-to-back reads stream at 1 per cycle.
- Write: single-cycle, no response.
- Read-during-write to the same address in consecutive cycles: the RAM returns new data because the write completes before the next access is issued. No extra hazard logic.
- reset_req mid-stream: a pending readdatavalid from the previous cycle is still delivered. New requests stall with waitrequest=1. last and streak are frozen.
- Async reset mid-read: the pending readdatavalid is dropped. Masters must not expect a response across reset.

Decomposition:
- Package pacman_soc_arb_pkg:
  - port-index type (1 bit)
  - streak width constant STREAK_W=4
  - streak saturation constant 15
- One natural sub-module: pacman_soc_rr_arb2, the 2-way round-robin/hold grant logic with last/streak registers.
- Datapath muxing and rd_pend stay in the top.

Test Plan:
- Reset, then m0 write addr 2 data 0xDEADBEEF be 0xF, then m0 read addr 2 -> m0_waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read with 0xDEADBEEF; m1_readdatavalid stays 0.
- Both ports read continuously, HOLD_MAX=1 -> accepts alternate 0,1,0,1; each readdatavalid arrives 1 cycle after its accept on the correct port.
- HOLD_MAX=3, both ports requesting continuously -> accept pattern 0,0,0,1,1,1,0,...; a waiting port is never stalled more than 3 cycles.
- m1 write be 0x3 data 0x1234_5678 to a word holding 0xAAAAAAAA, then m0 reads that word -> 0xAAAA5678.
- reset_req raised for 3 cycles in the middle of a read stream -> the read accepted just before still returns; both waitrequest=1 for 3 cycles; accepts resume with the correct round-robin order.
- Async reset asserted the cycle after a read accept -> no readdatavalid; after release, all outputs return to their reset values and the first contention is granted to port 0.

Source files
------------

// File: rtl/pacman_soc_arb_pkg.sv
// Shared types and constants for the pacman_soc on-chip RAM arbiter.
package pacman_soc_arb_pkg;

  typedef logic [0:0] port_idx_t;

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_SAT = 4'd15;

  typedef struct packed {
    logic      valid;
    port_idx_t port;
  } rd_pend_t;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s == STREAK_SAT) ? s : s + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/pacman_soc_rr_arb2.sv
// Two-way round-robin grant with a bounded hold streak for the current owner.
module pacman_soc_rr_arb2
  import pacman_soc_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [1:0] req,
  input  logic      hold,
  output logic      gnt_valid_c,
  output port_idx_t gnt_port_c
);

  localparam logic [STREAK_W-1:0] HOLD_LIM = STREAK_W'(HOLD_MAX);

  port_idx_t             last_q, last_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  owner_keeps;

  // streak==0 only after reset: no owner yet, so contention goes to ~last (port 0).
  always_comb begin
    gnt_valid_c = (|req) & ~hold;
    owner_keeps = (streak_q != '0) && (streak_q < HOLD_LIM);
    case (req)
      2'b01:   gnt_port_c = 1'b0;
      2'b10:   gnt_port_c = 1'b1;
      2'b11:   gnt_port_c = owner_keeps ? last_q : ~last_q;
      default: gnt_port_c = last_q;
    endcase
  end

  always_comb begin
    last_d   = last_q;
    streak_d = streak_q;
    if (gnt_valid_c) begin
      if (gnt_port_c == last_q) begin
        streak_d = streak_inc(streak_q);
      end else begin
        last_d   = gnt_port_c;
        streak_d = STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= 1'b1;
      streak_q <= '0;
    end else begin
      last_q   <= last_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/pacman_soc_onchip_mem_arbiter.sv
// Two-master arbiter in front of the single-port on-chip RAM; pipelined, 1-cycle read return.
module pacman_soc_onchip_mem_arbiter
  import pacman_soc_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 1,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic      gnt_valid_c;
  port_idx_t gnt_port_c;
  logic      acc0_c, acc1_c;
  rd_pend_t  rd_pend_q, rd_pend_d;

  // Reset also blocks accepts so waitrequest reads high while reset is asserted.
  pacman_soc_rr_arb2 #(
    .HOLD_MAX (HOLD_MAX)
  ) u_rr_arb2 (
    .clk         (clk),
    .reset       (reset),
    .req         ({m1_read | m1_write, m0_read | m0_write}),
    .hold        (reset_req | reset),
    .gnt_valid_c (gnt_valid_c),
    .gnt_port_c  (gnt_port_c)
  );

  assign acc0_c = gnt_valid_c & (gnt_port_c == 1'b0);
  assign acc1_c = gnt_valid_c & (gnt_port_c == 1'b1);

  assign m0_waitrequest = ~acc0_c;
  assign m1_waitrequest = ~acc1_c;

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = BE_W'(0);
    mem_writedata  = '0;
    if (acc0_c) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
    end else if (acc1_c) begin
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
  end

  // A write with read also set wins; the dropped read gets no response.
  always_comb begin
    rd_pend_d.valid = (acc0_c & m0_read & ~m0_write) | (acc1_c & m1_read & ~m1_write);
    rd_pend_d.port  = acc1_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend_q.valid & (rd_pend_q.port == 1'b0);
  assign m1_readdatavalid = rd_pend_q.valid & (rd_pend_q.port == 1'b1);

endmodule

// File: tb/tb_pacman_soc_onchip_mem_arbiter.sv
// Directed bench: RAM model behind the arbiter plus a HOLD_MAX=3 instance for hold-streak order.
module tb_pacman_soc_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset, reset_req;
  logic [1:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;

  logic        h0_read, h1_read;
  logic        h0_wait, h1_wait, h0_rdv, h1_rdv;
  logic [31:0] h0_rd, h1_rd;
  logic        h_cs, h_we;
  logic [1:0]  h_addr;
  logic [3:0]  h_be;
  logic [31:0] h_wd;

  logic [31:0] ram [4];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  pacman_soc_onchip_mem_arbiter #(.HOLD_MAX(1), .ADDR_W(2), .DATA_W(32)) u_dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata)
  );

  pacman_soc_onchip_mem_arbiter #(.HOLD_MAX(3), .ADDR_W(2), .DATA_W(32)) u_dut_h3 (
    .clk(clk), .reset(reset), .reset_req(1'b0),
    .m0_address(2'd0), .m0_byteenable(4'hF), .m0_read(h0_read),
    .m0_write(1'b0), .m0_writedata(32'd0), .m0_waitrequest(h0_wait),
    .m0_readdata(h0_rd), .m0_readdatavalid(h0_rdv),
    .m1_address(2'd1), .m1_byteenable(4'hF), .m1_read(h1_read),
    .m1_write(1'b0), .m1_writedata(32'd0), .m1_waitrequest(h1_wait),
    .m1_readdata(h1_rd), .m1_readdatavalid(h1_rdv),
    .mem_chipselect(h_cs), .mem_write(h_we), .mem_address(h_addr),
    .mem_byteenable(h_be), .mem_writedata(h_wd),
    .mem_readdata(32'h5A5A_0000)
  );

  // Single-port RAM model: byte-lane writes, registered read data.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  task automatic m_write(input int p, input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    idle_inputs();
    if (p == 0) begin
      m0_write = 1'b1; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_write = 1'b1; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  int g_tab [11] = '{1, 0, 1, 0, 1, 0, 2, 2, 2, 1, 0};
  int h_tab [9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
  int prev;

  initial begin
    reset = 1'b1; reset_req = 1'b0;
    idle_inputs();
    m0_address = 2'd2; m1_address = 2'd0; m0_byteenable = 4'hF; m1_byteenable = 4'h0;
    m0_writedata = 32'd0; m1_writedata = 32'd0;
    h0_read = 1'b0; h1_read = 1'b0;
    m0_read = 1'b1;

    // Held in reset with a pending request.
    @(negedge clk); #1;
    chk("rst_m0_wait", m0_waitrequest, 1'b1);
    chk("rst_m1_wait", m1_waitrequest, 1'b1);
    chk("rst_m0_rdv", m0_readdatavalid, 1'b0);
    chk("rst_m1_rdv", m1_readdatavalid, 1'b0);
    chk("rst_cs", mem_chipselect, 1'b0);
    chk("rst_addr", mem_address, 2'd0);

    // m0 write then read back.
    @(negedge clk);
    reset = 1'b0;
    m_write(0, 2'd2, 4'hF, 32'hDEAD_BEEF);
    #1;
    chk("wr_m0_wait", m0_waitrequest, 1'b0);
    chk("wr_cs", mem_chipselect, 1'b1);
    chk("wr_we", mem_write, 1'b1);
    chk("wr_addr", mem_address, 2'd2);
    chk("wr_data", mem_writedata, 32'hDEAD_BEEF);
    @(negedge clk);
    idle_inputs(); m0_read = 1'b1; m0_address = 2'd2;
    #1;
    chk("rd_m0_wait", m0_waitrequest, 1'b0);
    chk("rd_we", mem_write, 1'b0);
    chk("rd_m0_rdv_early", m0_readdatavalid, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rd_m0_rdv", m0_readdatavalid, 1'b1);
    chk("rd_m0_data", m0_readdata, 32'hDEAD_BEEF);
    chk("rd_m1_rdv", m1_readdatavalid, 1'b0);
    chk("idle_cs", mem_chipselect, 1'b0);

    // Partial-lane write from m1 over a full word.
    @(negedge clk);
    m_write(0, 2'd1, 4'hF, 32'hAAAA_AAAA);
    @(negedge clk);
    m_write(1, 2'd1, 4'h3, 32'h1234_5678);
    #1;
    chk("be_m1_wait", m1_waitrequest, 1'b0);
    chk("be_be", mem_byteenable, 4'h3);
    chk("be_addr", mem_address, 2'd1);
    @(negedge clk);
    idle_inputs(); m0_read = 1'b1; m0_address = 2'd1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("be_m0_rdv", m0_readdatavalid, 1'b1);
    chk("be_m0_data", m0_readdata, 32'hAAAA_5678);

    // Both read continuously; reset_req freezes arbitration for 3 cycles mid-stream.
    prev = 2;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      m0_read = 1'b1; m1_read = 1'b1; m0_address = 2'd2; m1_address = 2'd1;
      reset_req = (k >= 6 && k <= 8);
      #1;
      chk($sformatf("rr%0d_m0_wait", k), m0_waitrequest, g_tab[k] != 0);
      chk($sformatf("rr%0d_m1_wait", k), m1_waitrequest, g_tab[k] != 1);
      chk($sformatf("rr%0d_m0_rdv", k), m0_readdatavalid, prev == 0);
      chk($sformatf("rr%0d_m1_rdv", k), m1_readdatavalid, prev == 1);
      if (prev == 0) chk($sformatf("rr%0d_m0_data", k), m0_readdata, 32'hDEAD_BEEF);
      if (prev == 1) chk($sformatf("rr%0d_m1_data", k), m1_readdata, 32'hAAAA_5678);
      prev = g_tab[k];
    end
    @(negedge clk);
    idle_inputs(); reset_req = 1'b0;
    #1;
    chk("rr_tail_m0_rdv", m0_readdatavalid, 1'b1);
    chk("rr_tail_m1_rdv", m1_readdatavalid, 1'b0);

    // Async reset right after a read accept drops the response.
    @(negedge clk);
    m1_read = 1'b1; m1_address = 2'd1;
    #1;
    chk("ar_m1_wait", m1_waitrequest, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("ar_m1_rdv", m1_readdatavalid, 1'b0);
    chk("ar_m0_rdv", m0_readdatavalid, 1'b0);
    @(negedge clk);
    idle_inputs(); m0_read = 1'b1; m0_address = 2'd3; m0_byteenable = 4'hF;
    #1;
    chk("ar_m0_wait", m0_waitrequest, 1'b1);
    chk("ar_m1_wait", m1_waitrequest, 1'b1);
    chk("ar_cs", mem_chipselect, 1'b0);
    chk("ar_we", mem_write, 1'b0);
    chk("ar_addr", mem_address, 2'd0);
    chk("ar_be", mem_byteenable, 4'h0);
    chk("ar_wd", mem_writedata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m0_read = 1'b1; m1_read = 1'b1; m0_address = 2'd2; m1_address = 2'd1;
    #1;
    chk("ar_first_m0_wait", m0_waitrequest, 1'b0);
    chk("ar_first_m1_wait", m1_waitrequest, 1'b1);
    @(negedge clk); #1;
    chk("ar_second_m0_wait", m0_waitrequest, 1'b1);
    chk("ar_second_m1_wait", m1_waitrequest, 1'b0);
    chk("ar_second_m0_rdv", m0_readdatavalid, 1'b1);
    @(negedge clk);
    idle_inputs();

    // HOLD_MAX=3 instance: owner keeps at most 3 consecutive accepts under contention.
    prev = 2;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      h0_read = 1'b1; h1_read = 1'b1;
      #1;
      chk($sformatf("h3_%0d_m0_wait", k), h0_wait, h_tab[k] != 0);
      chk($sformatf("h3_%0d_m1_wait", k), h1_wait, h_tab[k] != 1);
      chk($sformatf("h3_%0d_cs", k), h_cs, 1'b1);
      chk($sformatf("h3_%0d_m0_rdv", k), h0_rdv, prev == 0);
      chk($sformatf("h3_%0d_m1_rdv", k), h1_rdv, prev == 1);
      prev = h_tab[k];
    end
    @(negedge clk);
    h0_read = 1'b0; h1_read = 1'b0;
    #1;
    chk("h3_tail_m0_rdv", h0_rdv, 1'b1);
    chk("h3_tail_data", h0_rd, 32'h5A5A_0000);
    chk("h3_tail_m1_data", h1_rd, 32'h5A5A_0000);
    chk("h3_tail_idle", {h_we, h_addr, h_be, h_wd[3:0]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
